matrix_scan_ctrl: RTL and testbench

- Row-scan controller for the 8x8 RGB LED matrix. It consumes the 8-row x 24-bit frame bitmaps produced by the pattern generators.
- Per row: snapshots the row, shifts 24 colour bits serially into the external column shift registers, then latches and drives the row for a fixed dwell time.
- Frame is captured once per scan, so the display never tears. A one-cycle frame_start pulse lets upstream logic (LFSR clk_en, game FSM) advance in step with the scan.

---
 rtl/matrix_scan_ctrl.sv | 173 +++++++++++++++++
 tb/tb_matrix_scan_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_ctrl.sv
// Row-scan controller for an 8x8 RGB LED matrix.
// Captures a full frame once per scan, shifts each row's 24 colour bits out to
// external column shift registers, latches them, then lights the row for a
// fixed dwell time.
module matrix_scan_ctrl #(
    parameter int unsigned CLK_DIV = 2,    // clk cycles per sh_clk half-period (1..255)
    parameter int unsigned BLANK   = 8,    // dark cycles before the latch pulse (1..255)
    parameter int unsigned DWELL   = 1000  // clk cycles a row stays lit (1..65535)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [7:0][23:0] frame_in,
    output logic             sh_data,
    output logic             sh_clk,
    output logic             sh_latch,
    output logic             oe_n,
    output logic [7:0]       row_sel,
    output logic             frame_start,
    output logic             frame_done,
    output logic             busy
);

    localparam logic [7:0]  PhaseLast = 8'(CLK_DIV - 1);
    localparam logic [7:0]  BlankLast = 8'(BLANK - 1);
    localparam logic [15:0] DwellLast = 16'(DWELL - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StShift,
        StBlank,
        StLatch,
        StDisplay
    } state_e;

    state_e           state_q, state_d;
    logic [2:0]       row_q, row_d;
    logic [4:0]       bit_q, bit_d;
    logic [7:0]       phase_q, phase_d;
    logic             hi_q, hi_d;
    logic [15:0]      dwell_q, dwell_d;
    logic [23:0]      sreg_q, sreg_d;
    logic [7:0][23:0] shadow_q, shadow_d;

    // State and datapath registers; reset puts the display dark immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            row_q    <= '0;
            bit_q    <= '0;
            phase_q  <= '0;
            hi_q     <= 1'b0;
            dwell_q  <= '0;
            sreg_q   <= '0;
            shadow_q <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            bit_q    <= bit_d;
            phase_q  <= phase_d;
            hi_q     <= hi_d;
            dwell_q  <= dwell_d;
            sreg_q   <= sreg_d;
            shadow_q <= shadow_d;
        end
    end

    // sh_clk and sh_data come straight from flops: hi_q is only ever set inside
    // SHIFT, and sreg_q has shifted in zeros by the time SHIFT ends.
    assign sh_clk  = hi_q;
    assign sh_data = sreg_q[23];

    // Next-state sequencing and decoded outputs.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        bit_d       = bit_q;
        phase_d     = phase_q;
        hi_d        = hi_q;
        dwell_d     = dwell_q;
        sreg_d      = sreg_q;
        shadow_d    = shadow_q;
        sh_latch    = 1'b0;
        oe_n        = 1'b1;
        row_sel     = 8'h00;
        frame_start = 1'b0;
        frame_done  = 1'b0;
        busy        = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StLoad;
                    row_d   = 3'd0;
                end
            end

            StLoad: begin
                // Row 0 takes its bits straight from frame_in since the shadow
                // copy only lands at the end of this cycle.
                if (row_q == 3'd0) begin
                    shadow_d    = frame_in;
                    frame_start = 1'b1;
                    sreg_d      = frame_in[0];
                end else begin
                    sreg_d = shadow_q[row_q];
                end
                bit_d   = 5'd0;
                phase_d = 8'd0;
                hi_d    = 1'b0;
                state_d = StShift;
            end

            StShift: begin
                if (phase_q == PhaseLast) begin
                    phase_d = 8'd0;
                    if (!hi_q) begin
                        hi_d = 1'b1;
                    end else begin
                        hi_d   = 1'b0;
                        sreg_d = {sreg_q[22:0], 1'b0};
                        bit_d  = bit_q + 5'd1;
                        if (bit_q == 5'd23) begin
                            state_d = StBlank;
                        end
                    end
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end

            StBlank: begin
                if (phase_q == BlankLast) begin
                    phase_d = 8'd0;
                    state_d = StLatch;
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end

            StLatch: begin
                sh_latch = 1'b1;
                dwell_d  = 16'd0;
                state_d  = StDisplay;
            end

            StDisplay: begin
                oe_n    = 1'b0;
                row_sel = 8'b1 << row_q;
                if (dwell_q == DwellLast) begin
                    frame_done = (row_q == 3'd7);
                    row_d      = row_q + 3'd1;
                    // Enable is only looked at here, so a row is never cut short.
                    if (enable) begin
                        state_d = StLoad;
                    end else begin
                        state_d = StIdle;
                        row_d   = 3'd0;
                    end
                end else begin
                    dwell_d = dwell_q + 16'd1;
                end
            end

            default: begin
                state_d = StIdle;
                row_d   = 3'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Directed bench for matrix_scan_ctrl: one instance at default timing, one at
// the minimum corner (CLK_DIV = BLANK = DWELL = 1).
module tb_matrix_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int num_checks = 0;
    int num_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- instance A: default parameters ----------------
    logic             rst_a_n, en_a;
    logic [7:0][23:0] frame_a;
    logic             sh_data_a, sh_clk_a, sh_latch_a, oe_n_a, frame_start_a, frame_done_a, busy_a;
    logic [7:0]       row_sel_a;

    matrix_scan_ctrl u_dut_a (
        .clk         (clk),
        .reset_n     (rst_a_n),
        .enable      (en_a),
        .frame_in    (frame_a),
        .sh_data     (sh_data_a),
        .sh_clk      (sh_clk_a),
        .sh_latch    (sh_latch_a),
        .oe_n        (oe_n_a),
        .row_sel     (row_sel_a),
        .frame_start (frame_start_a),
        .frame_done  (frame_done_a),
        .busy        (busy_a)
    );

    // ---------------- instance B: minimum timing ----------------
    logic             rst_b_n, en_b;
    logic [7:0][23:0] frame_b;
    logic             sh_data_b, sh_clk_b, sh_latch_b, oe_n_b, frame_start_b, frame_done_b, busy_b;
    logic [7:0]       row_sel_b;

    matrix_scan_ctrl #(
        .CLK_DIV (1),
        .BLANK   (1),
        .DWELL   (1)
    ) u_dut_b (
        .clk         (clk),
        .reset_n     (rst_b_n),
        .enable      (en_b),
        .frame_in    (frame_b),
        .sh_data     (sh_data_b),
        .sh_clk      (sh_clk_b),
        .sh_latch    (sh_latch_b),
        .oe_n        (oe_n_b),
        .row_sel     (row_sel_b),
        .frame_start (frame_start_b),
        .frame_done  (frame_done_b),
        .busy        (busy_b)
    );

    // ---------------- monitors (sample on falling edge) ----------------
    int          cyc = 0;
    logic        prev_clk_a = 1'b0, prev_oe_a = 1'b1, prev_clk_b = 1'b0;
    logic [23:0] stream_a = '0, stream_b = '0;
    int          edges_a = 0, hi_run_a = 0, oe_run_a = 0, hi_run_b = 0;
    int          lat_cyc_a[$], lat_edg_a[$], oe_len_a[$], fs_cyc_a[$], fd_cyc_a[$], hi_a[$];
    logic [23:0] lat_str_a[$];
    logic [7:0]  rs_a[$];
    int          lat_cyc_b[$], fs_cyc_b[$], fd_cyc_b[$], hi_b[$], rise_b[$];
    logic [23:0] lat_str_b[$];

    always @(negedge clk) begin
        cyc++;
        // instance A
        if (sh_clk_a && !prev_clk_a) begin
            stream_a = {stream_a[22:0], sh_data_a};
            edges_a++;
        end
        if (sh_clk_a) hi_run_a++;
        else if (hi_run_a != 0) begin
            if (hi_a.size() < 50) hi_a.push_back(hi_run_a);
            hi_run_a = 0;
        end
        if (sh_latch_a) begin
            lat_cyc_a.push_back(cyc);
            lat_str_a.push_back(stream_a);
            lat_edg_a.push_back(edges_a);
            stream_a = '0;
            edges_a  = 0;
        end
        if (!oe_n_a && prev_oe_a) rs_a.push_back(row_sel_a);
        if (!oe_n_a) oe_run_a++;
        else if (oe_run_a != 0) begin
            oe_len_a.push_back(oe_run_a);
            oe_run_a = 0;
        end
        if (frame_start_a) fs_cyc_a.push_back(cyc);
        if (frame_done_a) fd_cyc_a.push_back(cyc);
        prev_clk_a = sh_clk_a;
        prev_oe_a  = oe_n_a;
        // instance B (bounded history)
        if (sh_clk_b && !prev_clk_b) begin
            stream_b = {stream_b[22:0], sh_data_b};
            if (rise_b.size() < 40) rise_b.push_back(cyc);
        end
        if (sh_clk_b) hi_run_b++;
        else if (hi_run_b != 0) begin
            if (hi_b.size() < 40) hi_b.push_back(hi_run_b);
            hi_run_b = 0;
        end
        if (sh_latch_b) begin
            if (lat_cyc_b.size() < 40) begin
                lat_cyc_b.push_back(cyc);
                lat_str_b.push_back(stream_b);
            end
            stream_b = '0;
        end
        if (frame_start_b && fs_cyc_b.size() < 40) fs_cyc_b.push_back(cyc);
        if (frame_done_b && fd_cyc_b.size() < 40) fd_cyc_b.push_back(cyc);
        prev_clk_b = sh_clk_b;
    end

    // ---------------- bounded wait helpers ----------------
    task automatic wait_rs(input int n);
        int k = 0;
        while (rs_a.size() < n && k < 30000) begin
            @(posedge clk);
            k++;
        end
        check_val("wait_rows", 32'(rs_a.size() >= n), 32'd1);
    endtask

    task automatic wait_oe_high();
        int k = 0;
        while (oe_n_a !== 1'b1 && k < 3000) begin
            @(posedge clk);
            k++;
        end
        check_val("wait_oe_high", 32'(oe_n_a), 32'd1);
    endtask

    task automatic wait_fs(input int n);
        int k = 0;
        while (fs_cyc_a.size() < n && k < 30000) begin
            @(posedge clk);
            k++;
        end
        check_val("wait_frame_start", 32'(fs_cyc_a.size() >= n), 32'd1);
    endtask

    // {busy, oe_n, row_sel, sh_clk, sh_data, sh_latch, frame_start, frame_done}
    function automatic logic [31:0] outs_a();
        return 32'({busy_a, oe_n_a, row_sel_a, sh_clk_a, sh_data_a, sh_latch_a,
                    frame_start_a, frame_done_a});
    endfunction

    localparam logic [31:0] IdleVec = 32'({1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});

    // ---------------- main stimulus ----------------
    initial begin
        int          t_en, k;
        logic [23:0] exp_row;

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        en_a    = 1'b0;
        en_b    = 1'b1;
        for (int r = 0; r < 8; r++) frame_a[r] = 24'h003C00;
        frame_b[0] = 24'hA5C30F;
        frame_b[1] = 24'h5A3CF0;
        frame_b[2] = 24'h000001;
        frame_b[3] = 24'h800000;
        frame_b[4] = 24'hFFFFFF;
        frame_b[5] = 24'h123456;
        frame_b[6] = 24'hFEDCBA;
        frame_b[7] = 24'h0F0F0F;

        repeat (3) @(posedge clk);
        #1;
        check_val("reset_outputs", outs_a(), IdleVec);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_val("idle_hold_outputs", outs_a(), IdleVec);
        check_val("idle_no_latch", 32'(lat_cyc_a.size()), 32'd0);

        // Frame 1: 003C00 on every row.
        en_a = 1'b1;
        t_en = cyc;
        wait_rs(8);
        frame_a = {8{24'hFF0000}};  // picked up by frame 2's capture
        wait_fs(2);
        check_val("first_frame_start", 32'(fs_cyc_a[0]), 32'(t_en + 2));
        check_val("start_to_latch", 32'(lat_cyc_a[0] - fs_cyc_a[0]), 32'd105);
        check_val("frame_start_period", 32'(fs_cyc_a[1] - fs_cyc_a[0]), 32'd8848);
        check_val("frame_done_pos", 32'(fd_cyc_a[0] - fs_cyc_a[0]), 32'd8847);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("row_sel_%0d", i), 32'(rs_a[i]), 32'(8'h01 << i));
            check_val($sformatf("oe_low_len_%0d", i), 32'(oe_len_a[i]), 32'd1000);
        end
        for (int i = 0; i < 7; i++)
            check_val($sformatf("latch_gap_%0d", i), 32'(lat_cyc_a[i+1] - lat_cyc_a[i]), 32'd1106);
        check_val("sh_clk_high_first", 32'(hi_a[0]), 32'd2);
        check_val("sh_clk_high_last", 32'(hi_a[23]), 32'd2);

        // Frame 2: change frame_in during row 3 SHIFT; must not tear.
        wait_rs(11);
        wait_oe_high();
        repeat (10) @(posedge clk);
        #1;
        check_val("tear_in_shift", 32'(oe_n_a && busy_a && rs_a.size() == 11), 32'd1);
        frame_a = {8{24'h0000FF}};

        // Frame 3: drop enable during row 5 SHIFT.
        wait_rs(21);
        wait_oe_high();
        repeat (10) @(posedge clk);
        #1;
        en_a = 1'b0;
        k = 0;
        while (busy_a && k < 3000) begin
            @(posedge clk);
            k++;
        end
        #1;
        check_val("drop_reaches_idle", outs_a(), IdleVec);
        check_val("drop_rows_done", 32'(rs_a.size()), 32'd22);
        check_val("drop_row5_sel", 32'(rs_a[21]), 32'h20);
        check_val("drop_row5_dwell", 32'(oe_len_a[21]), 32'd1000);
        check_val("drop_no_frame_done", 32'(fd_cyc_a.size()), 32'd2);
        repeat (50) @(posedge clk);
        check_val("drop_stays_idle", 32'(lat_cyc_a.size()), 32'd22);

        // Re-enable: fresh capture, row 0 first.
        @(posedge clk);
        #1;
        en_a = 1'b1;
        t_en = cyc;
        wait_fs(4);
        check_val("reenable_frame_start", 32'(fs_cyc_a[3]), 32'(t_en + 2));
        wait_rs(23);
        check_val("reenable_row0", 32'(rs_a[22]), 32'h01);

        // Serial streams of every latched row so far.
        check_val("latch_count", 32'(lat_str_a.size()), 32'd23);
        for (int i = 0; i < 23; i++) begin
            exp_row = (i < 8) ? 24'h003C00 : (i < 16) ? 24'hFF0000 : 24'h0000FF;
            check_val($sformatf("stream_%0d", i), 32'(lat_str_a[i]), 32'(exp_row));
            check_val($sformatf("edges_%0d", i), 32'(lat_edg_a[i]), 32'd24);
        end

        // Asynchronous reset in the middle of row 1 SHIFT.
        wait_oe_high();
        k = 0;
        while (sh_clk_a !== 1'b1 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check_val("pre_reset_sh_clk", 32'(sh_clk_a), 32'd1);
        check_val("pre_reset_busy", 32'(busy_a), 32'd1);
        #2;
        rst_a_n = 1'b0;
        en_a    = 1'b0;
        #1;
        check_val("async_reset_outputs", outs_a(), IdleVec);
        repeat (3) @(posedge clk);
        #1;
        rst_a_n = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check_val("post_reset_hold", outs_a(), IdleVec);
        check_val("post_reset_no_latch", 32'(lat_cyc_a.size()), 32'd23);
        check_val("post_reset_no_start", 32'(fs_cyc_a.size()), 32'd4);

        // Minimum-timing instance has been scanning all along.
        check_val("b_latch_hist", 32'(lat_cyc_b.size() >= 10), 32'd1);
        for (int r = 0; r < 8; r++)
            check_val($sformatf("b_stream_%0d", r), 32'(lat_str_b[r]), 32'(frame_b[r]));
        check_val("b_start_to_latch", 32'(lat_cyc_b[0] - fs_cyc_b[0]), 32'd50);
        check_val("b_latch_gap", 32'(lat_cyc_b[1] - lat_cyc_b[0]), 32'd52);
        check_val("b_latch_gap_wrap", 32'(lat_cyc_b[8] - lat_cyc_b[7]), 32'd52);
        check_val("b_frame_done_gap", 32'(fd_cyc_b[1] - fd_cyc_b[0]), 32'd416);
        check_val("b_sh_clk_high", 32'(hi_b[0]), 32'd1);
        check_val("b_sh_clk_rise_gap", 32'(rise_b[1] - rise_b[0]), 32'd2);

        $display("CHECKS %0d ERRORS %0d", num_checks, num_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
